// File: rtl/tl_demand_arbiter.sv
// Demand-actuated round-robin phase arbiter for a three-approach intersection.
// Optional macro TL_NIGHT_FLASH_EN adds a night input and an all-yellow FLASH state.
module tl_demand_arbiter #(
    parameter int T_ALLRED = 5,
    parameter int T_PREP   = 2,
    parameter int T_GMIN   = 5,
    parameter int T_GMAX   = 10,
    parameter int T_YEL    = 2
) (
    input  logic       clk50M,
    input  logic       rst,
    input  logic       tick_1s,
    input  logic [2:0] req,
`ifdef TL_NIGHT_FLASH_EN
    input  logic       night,
`endif
    output logic [5:0] tfst,
    output logic [2:0] grant,
    output logic [2:0] pending
);

    typedef enum logic [2:0] {
        S_ALLRED = 3'd0,
        S_PREP   = 3'd1,
        S_GREEN  = 3'd2,
        S_YELLOW = 3'd3
`ifdef TL_NIGHT_FLASH_EN
        , S_FLASH = 3'd4
`endif
    } state_e;

    localparam logic [5:0] ALLRED_END = 6'(T_ALLRED - 1);
    localparam logic [5:0] PREP_END   = 6'(T_PREP - 1);
    localparam logic [5:0] GMIN_END   = 6'(T_GMIN - 1);
    localparam logic [5:0] GMAX_END   = 6'(T_GMAX - 1);
    localparam logic [5:0] YEL_END    = 6'(T_YEL - 1);

    state_e     state_q;
    logic [5:0] cnt_q;
    logic [1:0] last_q;
    logic [2:0] pending_q;
    logic [2:0] grant_q;
    logic [5:0] tfst_q;

    logic [2:0] pend_d;
    logic [1:0] c1, c2, c3;
    logic [1:0] sel_idx;
    logic [2:0] sel_oh;

    function automatic logic [5:0] fields(input logic [2:0] g, input logic [1:0] code);
        logic [5:0] f;
        f = '0;
        for (int i = 0; i < 3; i++)
            if (g[i]) f[2*i +: 2] = code;
        return f;
    endfunction

    function automatic logic [1:0] next_app(input logic [1:0] a);
        return (a >= 2'd2) ? 2'd0 : a + 2'd1;
    endfunction

    // Round-robin scan starts just after the last served approach.
    always_comb begin
        pend_d  = pending_q | (req & ~grant_q);
        c1      = next_app(last_q);
        c2      = next_app(c1);
        c3      = next_app(c2);
        sel_idx = c3;
        if (pending_q[c1])      sel_idx = c1;
        else if (pending_q[c2]) sel_idx = c2;
        sel_oh  = 3'b001 << sel_idx;
    end

    always_ff @(posedge clk50M or posedge rst) begin
        if (rst) begin
            state_q   <= S_ALLRED;
            cnt_q     <= '0;
            last_q    <= 2'd2;
            pending_q <= '0;
            grant_q   <= '0;
            tfst_q    <= '0;
        end else begin
            pending_q <= pend_d;
            case (state_q)
                S_ALLRED: begin
`ifdef TL_NIGHT_FLASH_EN
                    if (night && cnt_q == ALLRED_END) begin
                        state_q <= S_FLASH;
                        cnt_q   <= '0;
                        tfst_q  <= 6'b010101;
                    end else
`endif
                    if (tick_1s) begin
                        if (cnt_q < ALLRED_END) begin
                            cnt_q <= cnt_q + 6'd1;
                        end else if (|pending_q) begin
                            // Clearing the selected bit overrides a same-cycle set.
                            state_q   <= S_PREP;
                            cnt_q     <= '0;
                            last_q    <= sel_idx;
                            grant_q   <= sel_oh;
                            tfst_q    <= fields(sel_oh, 2'b11);
                            pending_q <= pend_d & ~sel_oh;
                        end
                    end
                end
                S_PREP: begin
                    if (tick_1s) begin
                        if (cnt_q == PREP_END) begin
                            state_q <= S_GREEN;
                            cnt_q   <= '0;
                            tfst_q  <= fields(grant_q, 2'b10);
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                S_GREEN: begin
                    if (tick_1s) begin
                        if (cnt_q == GMAX_END ||
                            (cnt_q >= GMIN_END && |(pending_q & ~grant_q))) begin
                            state_q <= S_YELLOW;
                            cnt_q   <= '0;
                            tfst_q  <= fields(grant_q, 2'b01);
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
                S_YELLOW: begin
                    if (tick_1s) begin
                        if (cnt_q == YEL_END) begin
                            state_q <= S_ALLRED;
                            cnt_q   <= '0;
                            grant_q <= '0;
                            tfst_q  <= '0;
                        end else begin
                            cnt_q <= cnt_q + 6'd1;
                        end
                    end
                end
`ifdef TL_NIGHT_FLASH_EN
                S_FLASH: begin
                    if (!night) begin
                        state_q <= S_ALLRED;
                        cnt_q   <= '0;
                        tfst_q  <= '0;
                    end else if (tick_1s) begin
                        tfst_q <= tfst_q ^ 6'b010101;
                    end
                end
`endif
                default: begin
                    state_q <= S_ALLRED;
                    cnt_q   <= '0;
                    grant_q <= '0;
                    tfst_q  <= '0;
                end
            endcase
        end
    end

    assign tfst    = tfst_q;
    assign grant   = grant_q;
    assign pending = pending_q;

endmodule

// File: doc/tl_demand_arbiter.md
Name: tl_demand_arbiter

Overview:
- Demand-actuated phase arbiter for the three-approach intersection.
- Approaches raise requests (detector loops or push-buttons). The block grants green to exactly one approach at a time, in round-robin order among those with pending demand.
- Every grant runs a prepare, green, yellow and all-red clearance sequence.
- Drives the packed 6-bit light-state bus consumed by the per-approach trafficlight decoders. Timing advances on a 1 s enable from the existing clock divider.

Parameters:
T_ALLRED, 5, all-red clearance ticks before any new grant
T_PREP, 2, red+yellow prepare ticks
T_GMIN, 5, minimum green ticks
T_GMAX, 10, maximum green ticks (T_GMIN <= T_GMAX <= 63)
T_YEL, 2, yellow ticks

Ports:
clk50M  in  1  system clock
rst  in  1  asynchronous active-high reset
tick_1s  in  1  one-clk50M-cycle pulse once per second
req  in  3  demand request per approach, level or pulse; bit i = approach i
tfst  out  6  light state; bits [2i+1:2i] = approach i; 00 red, 11 red+yellow, 10 green, 01 yellow
grant  out  3  one-hot approach currently in PREP, GREEN or YELLOW; 000 in ALLRED
pending  out  3  latched demand vector

Behaviour:
- Reset (async, active-high):
  - state=ALLRED, cnt=0, last=2 (approach 0 has first priority).
  - pending=000, grant=000, tfst=000000.
- All outputs are registered and all updates occur on posedge clk50M.
- Timing:
  - cnt is 6 bits and is cleared on every state entry.
  - cnt advances only on cycles with tick_1s=1.
  - A state lasting T ticks exits on the tick where cnt==T-1.
- Demand latch:
  - pending[i] is set by req[i]=1 on any clk50M cycle.
  - Exception: req[i] is ignored while approach i is granted.
  - pending[i] is cleared on the cycle the machine enters PREP for approach i.
- ALLRED (tfst=000000, grant=000):
  - cnt saturates at T_ALLRED-1.
  - On a tick with cnt==T_ALLRED-1 and pending!=0: select the first set bit scanning last+1, last+2, last+3 mod 3, then set last and grant, and go to PREP.
  - With no demand, ALLRED is held indefinitely.
  - A request arriving after saturation is served on the next tick.
- PREP (granted field=11): after T_PREP ticks, go to GREEN.
- GREEN (granted field=10):
  - Exit to YELLOW on a tick where cnt==T_GMAX-1.
  - Also exit to YELLOW on a tick where cnt>=T_GMIN-1 and pending has any bit other than the granted one.
  - Otherwise hold.
- YELLOW (granted field=01): after T_YEL ticks, go to ALLRED and clear grant.
- Invariants:
  - At most one approach field is non-00 at any time.
  - grant is one-hot or zero.
- Simultaneous events:
  - Set and clear of pending[i] on the same cycle: clear wins.
  - tick_1s coincident with rst: rst wins.
- Mid-operation reset immediately forces ALLRED with all lights red.
- An illegal state code recovers to ALLRED on the next clock.

Optional Feature:
Macro TL_NIGHT_FLASH_EN.
- Defined:
  - Adds input night (1 bit).
  - When night=1 and the machine is in ALLRED with cnt==T_ALLRED-1, it enters FLASH.
  - In FLASH, all three fields toggle between 01 and 00 on every tick, starting at 01. grant=000, and pending still latches.
  - When night=0, FLASH exits to ALLRED with cnt=0.
- Undefined: no night port and no FLASH state; behaviour is exactly as above.

Test Plan:
- Reset, then no req for 20 ticks -> tfst=000000, grant=000 throughout.
- req=001 pulse after reset -> after 5 ticks tfst=000011 for 2 ticks, then 000010 for 10 ticks, then 000001 for 2 ticks, then 000000; pending[0] cleared at PREP entry.
- req=111 held -> grants in order 001, 010, 100, 001; each green lasts 5 ticks (early termination at T_GMIN).
- Approach 1 green with no other demand, then req[2] pulse at green tick 7 -> yellow starts on green tick 8.
- Assert rst mid-GREEN for approach 2 -> tfst=000000, grant=000, pending=000 asynchronously; the next grant goes to approach 0 when all three are requested.
- With TL_NIGHT_FLASH_EN, night=1 -> after all-red, tfst alternates 010101 and 000000 each tick; night=0 -> all-red, then normal arbitration.
